event_blinker: RTL and testbench

- Converts single-cycle internal events into human-visible LED blinks.
- This is the output-side counterpart of the push-button debounce path: debounce turns human-timescale input into a clock-cycle pulse; event_blinker turns clock-cycle pulses into millisecond-scale output.
- Events are counted in a saturating pending counter and replayed as ON/GAP blink sequences.
- Sits between control logic (e.g. debounced start pulses, FSM done strobes) and board LEDs on the DE2-115.

---
 rtl/event_blinker_pkg.sv | 28 ++
 rtl/ms_timer.sv | 26 ++
 rtl/event_blinker.sv | 128 ++++++++++++
 tb/tb_event_blinker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/event_blinker_pkg.sv
// Shared types and sizing helpers for the event blinker.
package event_blinker_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StGap  = 2'd2
  } state_e;

  function automatic int unsigned cycles_per_ms(input int unsigned fpga_clk);
    return fpga_clk / 1000;
  endfunction

  function automatic int unsigned pend_width(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

  // At least one bit so a 1-cycle phase still gets a legal counter.
  function automatic int unsigned timer_width(input int unsigned on_cyc,
                                              input int unsigned off_cyc);
    int unsigned m;
    int unsigned w;
    m = (on_cyc > off_cyc) ? on_cyc : off_cyc;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Phase timer: counts up from restart and parks at the terminal count.
module ms_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic [TW-1:0] terminal,
  output logic          done
);

  logic [TW-1:0] r_count;

  assign done = (r_count == terminal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (restart) begin
      r_count <= '0;
    end else if (!done) begin
      r_count <= r_count + TW'(1);
    end
  end

endmodule

// File: rtl/event_blinker.sv
// Queues single-cycle events and replays each one as an ON blink followed by a dark GAP.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int unsigned FPGA_CLK = 50000000,
  parameter int unsigned ON_MS    = 100,
  parameter int unsigned OFF_MS   = 100,
  parameter int unsigned MAX_PEND = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            event_in,
  output logic                            led_out,
  output logic                            busy,
  output logic [$clog2(MAX_PEND+1)-1:0]   pending,
  output logic                            overflow
);

  localparam int unsigned CycMs  = cycles_per_ms(FPGA_CLK);
  localparam int unsigned OnCyc  = CycMs * ON_MS;
  localparam int unsigned OffCyc = CycMs * OFF_MS;
  localparam int unsigned PW     = pend_width(MAX_PEND);
  localparam int unsigned TW     = timer_width(OnCyc, OffCyc);

  localparam logic [PW-1:0] MaxPend = PW'(MAX_PEND);
  localparam logic [TW-1:0] OnTerm  = TW'(OnCyc - 1);
  localparam logic [TW-1:0] OffTerm = TW'(OffCyc - 1);

  state_e          r_state;
  state_e          w_state_d;
  logic [PW-1:0]   r_pending;
  logic [PW-1:0]   w_pending_d;
  logic            r_overflow;
  logic            w_overflow_d;
  logic            r_event_prev;
  logic            r_led;
  logic            r_busy;
  logic            w_edge;
  logic            w_dequeue;
  logic            w_done;
  logic            w_restart;
  logic [TW-1:0]   w_terminal;

  assign w_edge     = event_in & ~r_event_prev;
  assign w_terminal = (r_state == StOn) ? OnTerm : OffTerm;
  // Timer restarts on every phase change and is held at zero while idle.
  assign w_restart  = (w_state_d != r_state) || (r_state == StIdle);

  ms_timer #(
    .TW(TW)
  ) u_ms_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .terminal(w_terminal),
    .done    (w_done)
  );

  always_comb begin
    w_state_d = r_state;
    w_dequeue = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_pending != '0) begin
          w_dequeue = 1'b1;
          w_state_d = StOn;
        end
      end
      StOn: begin
        if (w_done) w_state_d = StGap;
      end
      StGap: begin
        if (w_done) begin
          if (r_pending != '0) begin
            w_dequeue = 1'b1;
            w_state_d = StOn;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (clear) begin
      w_state_d = StIdle;
      w_dequeue = 1'b0;
    end
  end

  always_comb begin
    w_pending_d  = r_pending;
    w_overflow_d = r_overflow;
    if (clear) begin
      w_pending_d  = '0;
      w_overflow_d = 1'b0;
    end else if (w_edge && !w_dequeue) begin
      if (r_pending != MaxPend) w_pending_d = r_pending + PW'(1);
      else                      w_overflow_d = 1'b1;
    end else if (!w_edge && w_dequeue) begin
      w_pending_d = r_pending - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_pending    <= '0;
      r_overflow   <= 1'b0;
      r_event_prev <= 1'b0;
      r_led        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_pending    <= w_pending_d;
      r_overflow   <= w_overflow_d;
      r_event_prev <= event_in;
      r_led        <= (w_state_d == StOn);
      r_busy       <= (w_state_d != StIdle);
    end
  end

  assign led_out  = r_led;
  assign busy     = r_busy;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_event_blinker.sv
// Directed and randomized checks of event_blinker against a blink-occupancy reference model.
module tb_event_blinker;

  localparam int unsigned FpgaClk = 4000;
  localparam int unsigned OnMs    = 2;
  localparam int unsigned OffMs   = 1;
  localparam int unsigned MaxPend = 3;
  localparam int          OnCyc   = (FpgaClk / 1000) * OnMs;
  localparam int          OffCyc  = (FpgaClk / 1000) * OffMs;
  localparam int          Period  = OnCyc + OffCyc;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       event_in;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int rises    = 0;
  logic last_led = 1'b0;

  // Reference model: pending count, sticky overflow, and cycles left in the current blink.
  int   m_pend;
  int   m_left;
  logic m_ovf;
  logic m_prev;

  event_blinker #(
    .FPGA_CLK(FpgaClk),
    .ON_MS   (OnMs),
    .OFF_MS  (OffMs),
    .MAX_PEND(MaxPend)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .event_in(event_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_left = 0;
    m_ovf  = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic model_step(input logic ev, input logic clr);
    logic ev_edge;
    logic start;
    ev_edge = ev && !m_prev;
    if (clr) begin
      m_pend = 0;
      m_ovf  = 1'b0;
      m_left = 0;
    end else begin
      // A new blink may begin when idle or in the final cycle of the previous gap.
      start = (m_pend > 0) && (m_left <= 1);
      if (ev_edge && !start) begin
        if (m_pend < MaxPend) m_pend++;
        else                  m_ovf = 1'b1;
      end else if (!ev_edge && start) begin
        m_pend--;
      end
      m_left = start ? Period : ((m_left > 0) ? m_left - 1 : 0);
    end
    m_prev = ev;
  endtask

  task automatic compare_all();
    chk("led_out",  led_out,  (m_left > OffCyc));
    chk("busy",     busy,     (m_left > 0));
    chk("pending",  pending,  m_pend);
    chk("overflow", overflow, m_ovf);
  endtask

  // Called at posedge+1; drives inputs, steps one clock, checks at posedge+1.
  task automatic cycle(input logic ev, input logic clr);
    event_in = ev;
    clear    = clr;
    @(posedge clk);
    model_step(ev, clr);
    #1;
    compare_all();
    if (led_out && !last_led) rises++;
    last_led = led_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic async_reset(input logic ev_hold);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(posedge clk);
    #1;
    event_in = ev_hold;
    clear    = 1'b0;
    last_led = 1'b0;
    rst      = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int cnt;
    int p;
    rst      = 1'b0;
    clear    = 1'b0;
    event_in = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single pulse: ON lasts exactly OnCyc cycles.
    idle(9);
    cycle(1'b1, 1'b0);
    chk("single_pending", pending, 1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(1'b0, 1'b0);
      if (led_out) cnt++;
    end
    chk("single_on_len", cnt, OnCyc);
    chk("single_idle", busy, 0);

    // Held level counts once.
    r0 = rises;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
    idle(20);
    chk("held_blinks", rises - r0, 1);

    // Back-to-back pulses.
    r0 = rises;
    for (int i = 0; i < 5; i++) cycle(logic'(i % 2 == 0), 1'b0);
    chk("b2b_peak", pending, 2);
    idle(45);
    chk("b2b_blinks", rises - r0, 3);
    chk("b2b_ovf", overflow, 0);

    // Overflow at saturation, sticky after drain.
    r0 = rises;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
    idle(60);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_blinks", rises - r0, 4);

    // Clear mid-blink with a same-cycle edge.
    for (int i = 0; i < 6; i++) cycle(logic'(i % 2 == 0), 1'b0);
    chk("clr_pre_pend", pending, 2);
    cycle(1'b1, 1'b1);
    chk("clr_led", led_out, 0);
    chk("clr_pend", pending, 0);
    chk("clr_ovf", overflow, 0);
    r0 = rises;
    idle(30);
    chk("clr_no_blinks", rises - r0, 0);

    // Async reset mid-gap, release with event held high.
    for (int i = 0; i < 5; i++) cycle(logic'(i % 2 == 0), 1'b0);
    idle(6);
    async_reset(1'b1);
    cycle(1'b1, 1'b0);
    chk("rst_pend", pending, 1);
    cycle(1'b1, 1'b0);
    chk("rst_led", led_out, 1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    idle(5);

    // Randomized traffic with occasional clears and one async reset.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       p = 5;
        1:       p = 30;
        default: p = 70;
      endcase
      if (i == 1500) async_reset(logic'($urandom_range(0, 1)));
      else cycle(logic'($urandom_range(0, 99) < p), logic'($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
